// File: rtl/hash_job_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | hash_job_arbiter: round-robin share of one hash engine among NUM_REQ  |
// | requesters. Optional abort-on-timeout: define ARB_TIMEOUT_EN.         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module hash_job_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ID_W       = 2,
   parameter int MAX_CYCLES = 65535
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [96*NUM_REQ-1:0] payload_in,
   input  logic [8*NUM_REQ-1:0]  target_in,
   output logic [NUM_REQ-1:0]    grant,
   output logic [NUM_REQ-1:0]    done,
   output logic                  err,
   output logic [31:0]           nonce_res,
   output logic [23:0]           hash_res,
   output logic                  busy,
   output logic [95:0]           eng_payload,
   output logic [7:0]            eng_target,
   output logic                  eng_active,
   input  logic                  eng_terminado,
   input  logic [31:0]           eng_nonce,
   input  logic [23:0]           eng_hash
);

   localparam logic [ID_W-1:0] c_last_id = ID_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W != $clog2(NUM_REQ) || MAX_CYCLES < 1) begin : g_param_check
      $error("hash_job_arbiter: unsupported parameter set");
   end

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ID_W-1:0]     r_id;
   logic [ID_W-1:0]     w_win;
   logic                w_found;
   logic [95:0]         w_pay;
   logic [7:0]          w_tgt;
   logic                r_first;
   logic                w_accept;
   logic                w_finish;
   logic                w_abort;
   logic                w_timeout;
   logic [NUM_REQ-1:0]  r_grant;
   logic [NUM_REQ-1:0]  r_done;
   logic [31:0]         r_nonce;
   logic [23:0]         r_hash;
   logic [95:0]         r_eng_payload;
   logic [7:0]          r_eng_target;
   logic                r_eng_active;

   function automatic logic [NUM_REQ-1:0] f_onehot(input logic [ID_W-1:0] id);
      logic [NUM_REQ-1:0] v;
      v     = '0;
      v[id] = 1'b1;
      return v;
   endfunction

   // Round-robin search starts just above the last granted index.
   always_comb begin : p_arb
      int idx;
      idx     = 0;
      w_found = 1'b0;
      w_win   = r_id;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(r_id) + k) % NUM_REQ;
         if (!w_found && req[idx[ID_W-1:0]]) begin
            w_found = 1'b1;
            w_win   = idx[ID_W-1:0];
         end
      end
   end

   always_comb begin : p_mux
      w_pay = '0;
      w_tgt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_win == ID_W'(i)) begin
            w_pay = payload_in[96*i +: 96];
            w_tgt = target_in[8*i +: 8];
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [31:0] c_cnt_last = 32'(MAX_CYCLES - 1);
   logic [31:0] r_cnt;
   logic        r_err;

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= '0;
      end else if (r_state == S_RUN) begin
         r_cnt <= r_cnt + 32'd1;
      end
   end

   assign w_timeout = (r_state == S_RUN) && (r_cnt == c_cnt_last);

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         r_err <= 1'b0;
      end else if (w_finish) begin
         r_err <= 1'b0;
      end else if (w_abort) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign w_timeout = 1'b0;
   assign err       = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // The engine may still show terminado from the previous job during the
   // first RUN cycle, so completion is only honoured once r_first is clear.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_finish    = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (!r_first && eng_terminado) begin
               w_finish    = 1'b1;
               w_state_nxt = S_GAP;
            end else if (w_timeout) begin
               w_abort     = 1'b1;
               w_state_nxt = S_GAP;
            end
         end
         S_GAP:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         r_id          <= c_last_id;
         r_first       <= 1'b0;
         r_grant       <= '0;
         r_done        <= '0;
         r_nonce       <= '0;
         r_hash        <= '0;
         r_eng_payload <= '0;
         r_eng_target  <= '0;
         r_eng_active  <= 1'b0;
      end else begin
         r_grant <= '0;
         r_done  <= '0;
         if (r_state == S_RUN) begin
            r_first <= 1'b0;
         end
         if (w_accept) begin
            r_id          <= w_win;
            r_first       <= 1'b1;
            r_grant       <= f_onehot(w_win);
            r_eng_payload <= w_pay;
            r_eng_target  <= w_tgt;
            r_eng_active  <= 1'b1;
         end
         if (w_finish) begin
            r_nonce      <= eng_nonce;
            r_hash       <= eng_hash;
            r_done       <= f_onehot(r_id);
            r_eng_active <= 1'b0;
         end else if (w_abort) begin
            r_nonce      <= 32'h0;
            r_hash       <= 24'hFFFFFF;
            r_done       <= f_onehot(r_id);
            r_eng_active <= 1'b0;
         end
      end
   end

   assign grant       = r_grant;
   assign done        = r_done;
   assign nonce_res   = r_nonce;
   assign hash_res    = r_hash;
   assign eng_payload = r_eng_payload;
   assign eng_target  = r_eng_target;
   assign eng_active  = r_eng_active;
   assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hash_job_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | tb_hash_job_arbiter: directed self-checking bench for hash_job_arbiter|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_hash_job_arbiter;

   localparam int N = 4;

   logic            clk = 1'b0;
   logic            reset_L;
   logic [N-1:0]    req;
   logic [96*N-1:0] payload_in;
   logic [8*N-1:0]  target_in;
   logic [N-1:0]    grant;
   logic [N-1:0]    done;
   logic            err;
   logic [31:0]     nonce_res;
   logic [23:0]     hash_res;
   logic            busy;
   logic [95:0]     eng_payload;
   logic [7:0]      eng_target;
   logic            eng_active;
   logic            eng_terminado = 1'b0;
   logic [31:0]     eng_nonce     = '0;
   logic [23:0]     eng_hash      = '0;

   int              n_cmp     = 0;
   int              n_err     = 0;
   int              cyc       = 0;
   int              n_overlap = 0;
   int              run_len   = 0;
   int              ecnt      = 0;
   bit              hold_term = 1'b0;
   logic [31:0]     job_nonce = '0;
   logic [23:0]     job_hash  = '0;
   int              g;
   int              n;
   logic [N-1:0]    exp_g;

   hash_job_arbiter #(.NUM_REQ(N), .ID_W(2), .MAX_CYCLES(16)) dut (
      .clk(clk), .reset_L(reset_L), .req(req), .payload_in(payload_in),
      .target_in(target_in), .grant(grant), .done(done), .err(err),
      .nonce_res(nonce_res), .hash_res(hash_res), .busy(busy),
      .eng_payload(eng_payload), .eng_target(eng_target), .eng_active(eng_active),
      .eng_terminado(eng_terminado), .eng_nonce(eng_nonce), .eng_hash(eng_hash)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // Engine model: terminado rises after run_len active cycles; with hold_term
   // a stale terminado survives into the first active cycle of the next job.
   always @(negedge clk) begin
      if (!eng_active) begin
         ecnt = 0;
         if (!hold_term) eng_terminado = 1'b0;
      end else begin
         ecnt = ecnt + 1;
         if (ecnt == run_len) begin
            eng_terminado = 1'b1;
            eng_nonce     = job_nonce;
            eng_hash      = job_hash;
         end else if (ecnt >= 2) begin
            eng_terminado = 1'b0;
         end
      end
   end

   always @(negedge clk) if (grant != 0 && done != 0) n_overlap++;

   task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset_L = 1'b0;
      tick;
      reset_L = 1'b1;
   endtask

   task automatic wait_grant(input string tag, input int budget);
      int k;
      k = 0;
      while (grant == 0 && k < budget) begin
         tick;
         k++;
      end
      check_val({tag, "_grant_seen"}, 128'(grant != 0), 1);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k;
      k = 0;
      while (done == 0 && k < budget) begin
         tick;
         k++;
      end
      check_val({tag, "_done_seen"}, 128'(done != 0), 1);
   endtask

   initial begin
      reset_L    = 1'b0;
      req        = '0;
      payload_in = {96'hfeedfacecafef00d0badbeef, 96'hdeadbeef0123456789abcdef,
                    96'h111122223333444455556666, 96'h397d9f2f40ca9e6c6b1f3324};
      target_in  = {8'h33, 8'h22, 8'h11, 8'h0a};
      tick; tick; tick;
      check_val("rst_ctrl", {grant, done, err, busy, eng_active}, 0);
      check_val("rst_payload", eng_payload, 0);
      check_val("rst_target", eng_target, 0);
      check_val("rst_nonce", nonce_res, 0);
      check_val("rst_hash", hash_res, 0);
      reset_L = 1'b1;
      tick;

      // Single job, 20-cycle engine
      job_nonce = 32'h0000_1234; job_hash = 24'h05abcd; run_len = 20;
      req = 4'b0001;
      tick;
      check_val("t1_grant", grant, 4'b0001);
      check_val("t1_active", eng_active, 1);
      check_val("t1_payload", eng_payload, 96'h397d9f2f40ca9e6c6b1f3324);
      check_val("t1_target", eng_target, 8'h0a);
      g = cyc;
      req = '0;
      tick;
      check_val("t1_grant_pulse", grant, 0);
      wait_done("t1", 100);
      check_val("t1_done", done, 4'b0001);
      check_val("t1_latency", cyc - g, 20);
      check_val("t1_err", err, 0);
      check_val("t1_nonce", nonce_res, 32'h1234);
      check_val("t1_hash", hash_res, 24'h05abcd);
      check_val("t1_gap_state", {eng_active, busy}, 2'b01);
      tick;
      check_val("t1_idle_state", {eng_active, busy, done}, 0);
      check_val("t1_nonce_held", nonce_res, 32'h1234);

      // All requesters pending: rotation 0,1,2,3,0
      do_reset;
      run_len = 5; req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         job_nonce = 32'h100 + 32'(j); job_hash = 24'h200 + 24'(j);
         exp_g = 4'b0001 << (j % 4);
         wait_grant("t2", 20);
         check_val("t2_grant", grant, exp_g);
         g = cyc;
         wait_done("t2", 20);
         check_val("t2_done", done, exp_g);
         check_val("t2_latency", cyc - g, 5);
         check_val("t2_nonce", nonce_res, 32'h100 + 32'(j));
      end
      req = '0;

      // Reset in the middle of a job
      tick; tick;
      run_len = 30; job_nonce = 32'h9999;
      req = 4'b0001;
      wait_grant("t3a", 20);
      req = '0;
      tick; tick; tick;
      reset_L = 1'b0;
      tick;
      check_val("t3_rst_ctrl", {grant, done, err, busy, eng_active}, 0);
      check_val("t3_rst_nonce", nonce_res, 0);
      check_val("t3_rst_payload", eng_payload, 0);
      reset_L = 1'b1;
      n = 0;
      repeat (40) begin
         tick;
         if (done != 0) n++;
      end
      check_val("t3_no_done", n, 0);
      run_len = 4; job_nonce = 32'h3333; job_hash = 24'h000333; hold_term = 1'b1;
      req = 4'b0100;
      wait_grant("t3b", 20);
      check_val("t3_grant", grant, 4'b0100);
      check_val("t3_target", eng_target, 8'h22);
      req = '0;
      wait_done("t3b", 20);
      check_val("t3_done", done, 4'b0100);
      check_val("t3_nonce", nonce_res, 32'h3333);

      // Stale terminado held into the first RUN cycle
      job_nonce = 32'hAAAA_0004; job_hash = 24'h0004aa; run_len = 6;
      req = 4'b0001;
      wait_grant("t4", 20);
      check_val("t4_grant", grant, 4'b0001);
      g = cyc;
      hold_term = 1'b0; req = '0;
      wait_done("t4", 20);
      check_val("t4_latency", cyc - g, 6);
      check_val("t4_nonce", nonce_res, 32'hAAAA_0004);
      check_val("t4_hash", hash_res, 24'h0004aa);

      // Request dropped while another job runs forfeits
      run_len = 8; job_nonce = 32'h5555;
      req = 4'b0001;
      wait_grant("t5a", 20);
      check_val("t5_grant0", grant, 4'b0001);
      req = 4'b0010;
      tick; tick;
      req = '0;
      wait_done("t5a", 20);
      check_val("t5_done0", done, 4'b0001);
      req = 4'b1000;
      wait_grant("t5b", 20);
      check_val("t5_grant3", grant, 4'b1000);
      req = '0;
      wait_done("t5b", 20);
      check_val("t5_done3", done, 4'b1000);
      n = 0;
      repeat (10) begin
         tick;
         if (grant != 0) n++;
      end
      check_val("t5_no_grant", n, 0);

      // Engine never finishes
      do_reset;
      run_len = 0;
      req = 4'b0001;
      wait_grant("t6", 20);
      g = cyc;
      req = '0;
`ifdef ARB_TIMEOUT_EN
      wait_done("t6", 100);
      check_val("t6_done", done, 4'b0001);
      check_val("t6_latency", cyc - g, 16);
      check_val("t6_err", err, 1);
      check_val("t6_nonce", nonce_res, 0);
      check_val("t6_hash", hash_res, 24'hFFFFFF);
      check_val("t6_active", eng_active, 0);
`else
      n = 0;
      repeat (40) begin
         tick;
         if (done != 0) n++;
      end
      check_val("t6_no_done", n, 0);
      check_val("t6_busy", busy, 1);
      check_val("t6_active", eng_active, 1);
      check_val("t6_err", err, 0);
`endif
      do_reset;

      check_val("grant_done_overlap", n_overlap, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hash_job_arbiter.md
Name: hash_job_arbiter

Overview:
Shares one hash engine (sistema_speed-style: payload/active/target in, terminado/nonceOut/hashOut out) among NUM_REQ requesters. Round-robin arbitration; latches the winner's payload and target into the engine and sequences its active input. Waits for terminado, then returns nonce/hash to the granted requester with a one-cycle done pulse. Sits between the job sources and the single mining core in the top-level system.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of the granted-index register, clog2(NUM_REQ)
MAX_CYCLES, 65535, run-cycle limit before abort (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
reset_L  in  1  synchronous active-low reset
req  in  NUM_REQ  per-requester job request, level; held until grant
payload_in  in  96*NUM_REQ  packed payloads; requester i at bits [96i+95:96i]
target_in  in  8*NUM_REQ  packed targets; requester i at bits [8i+7:8i]
grant  out  NUM_REQ  one-hot, one-cycle pulse when a job is accepted
done  out  NUM_REQ  one-hot, one-cycle pulse when a result is valid
err  out  1  valid with done; 1 = job aborted by timeout
nonce_res  out  32  result nonce, held until the next done
hash_res  out  24  result hash, held until the next done
busy  out  1  high in any state other than IDLE
eng_payload  out  96  engine payload, registered
eng_target  out  8  engine target, registered
eng_active  out  1  engine run enable
eng_terminado  in  1  engine finished
eng_nonce  in  32  engine nonce
eng_hash  in  24  engine hash

Behaviour:
- Reset (reset_L=0 at a rising edge): every output is 0, state = IDLE, rr_ptr = NUM_REQ-1, cycle counter = 0. Reset mid-job drops eng_active in the same edge, discards the job and issues no done.
- States: IDLE, RUN, GAP.
- IDLE:
  - eng_active = 0.
  - If req != 0 at an edge, the winner is the first set bit searching upward from rr_ptr+1 modulo NUM_REQ.
  - On that edge: latch the winner's payload/target into eng_payload/eng_target, store the id, set rr_ptr = id, set grant[id] = 1 for exactly one cycle, set eng_active = 1, go to RUN.
  - Latency: req sampled at edge t, so grant and eng_active are high in cycle t+1.
- RUN:
  - eng_active = 1; eng_payload/eng_target are stable.
  - eng_terminado is ignored in the first RUN cycle, because the engine output may still reflect the previous job.
  - From the second cycle, eng_terminado = 1 at an edge triggers all of the following on that edge: nonce_res <= eng_nonce, hash_res <= eng_hash, err <= 0, done[id] = 1 for one cycle, eng_active <= 0, go to GAP.
- GAP:
  - One cycle with eng_active = 0, guaranteeing the engine sees at least one inactive cycle between jobs.
  - Then IDLE. Requests are not sampled in GAP.
- Request rules:
  - req changes during RUN/GAP are ignored.
  - A requester dropping req before grant forfeits.
  - The granted requester may reassert req immediately; it loses to any other pending requester on the next arbitration.
- Throughput: back-to-back jobs need at least 4 cycles of arbiter overhead plus engine run time. There is no queueing.
- grant and done never assert in the same cycle.
- done[i] only follows grant[i] for the same job.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches MAX_CYCLES before terminado: done[id] = 1, err = 1, nonce_res = 32'h0, hash_res = 24'hFFFFFF, eng_active <= 0, go to GAP.
  - If terminado and timeout occur on the same edge, terminado wins (err = 0).
- Not defined: no counter is synthesized, err is tied 0, and RUN waits indefinitely.

Test Plan:
1. Reset, then req=4'b0001, payload0=96'h397d9f2f40ca9e6c6b1f3324, target0=8'h0a; engine model raises terminado after 20 cycles with nonce 32'h0000_1234, hash 24'h05abcd -> grant=0001 one cycle after req; eng_payload/eng_target match; done=0001, err=0, nonce_res=32'h1234, hash_res=24'h05abcd; eng_active low for exactly one GAP cycle.
2. req=4'b1111 held continuously, engine done in 5 cycles -> grant order 0,1,2,3,0; each done pulse matches the preceding grant id.
3. reset_L=0 for one cycle while in RUN -> eng_active, busy and all outputs 0 on the next cycle; no done pulse; next req=4'b0100 is granted index 2.
4. Engine holds terminado=1 from the previous job into the first RUN cycle -> ignored; result is taken only from a terminado seen on the second or later RUN cycle.
5. req=4'b0010 dropped during RUN of job 0, then req=4'b1000 -> only index 3 is granted next; index 1 is never granted.
6. ARB_TIMEOUT_EN with MAX_CYCLES=16 and terminado never asserted -> done after 16 RUN cycles, err=1, nonce_res=0, hash_res=24'hFFFFFF; without the macro busy stays high and err stays 0.
